uc_host_link: RTL and testbench

Host-side end of the EPT microcontroller link: serialises host write requests into `uc_in` frames that device-side transfer endpoints decode, and captures `TRANSFER_OUT` frames that endpoints drive on `uc_out`. The block also generates the `uc_in` busy handshake that endpoints wait on before releasing `transfer_busy`. It sits between the USB/host bridge logic and all device endpoints sharing the `uc_in`/`uc_out` buses.

---
 rtl/uc_host_link_pkg.sv | 29 ++
 rtl/uc_rx_fifo.sv | 47 ++++
 rtl/uc_host_link.sv | 144 ++++++++++++++
 tb/tb_uc_host_link.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uc_host_link_pkg.sv
// uc_host_link_pkg: uc_in/uc_out field layout, command codes and TX FSM states shared with endpoints
package uc_host_link_pkg;
    localparam int UC_DATA_LSB = 0;
    localparam int UC_DATA_W   = 8;
    localparam int UC_CMD_LSB  = 8;
    localparam int UC_CMD_W    = 3;
    localparam int UC_ADDR_LSB = 11;
    localparam int UC_ADDR_W   = 3;
    localparam int UC_LEN_LSB  = 14;
    localparam int UC_LEN_W    = 8;
    localparam int UC_BUSY_BIT = 22;
    localparam int UC_IN_W     = 23;
    localparam int UC_OUT_W    = 22;

    localparam logic [2:0] CMD_NOP          = 3'd0;
    localparam logic [2:0] CMD_TRANSFER_IN  = 3'd1;
    localparam logic [2:0] CMD_TRIGGER_IN   = 3'd2;
    localparam logic [2:0] CMD_BLOCK_IN     = 3'd3;
    localparam logic [2:0] CMD_TRANSFER_OUT = 3'd4;

    localparam logic [UC_IN_W-1:0] UC_IN_IDLE = '0;

    typedef enum logic [1:0] {TX_IDLE, TX_HOLD, TX_GAP} tx_state_t;

    // Commands the host may send down to endpoints
    function automatic logic is_down_cmd(input logic [2:0] cmd);
        return cmd inside {CMD_TRANSFER_IN, CMD_TRIGGER_IN, CMD_BLOCK_IN};
    endfunction
endpackage

// File: rtl/uc_rx_fifo.sv
// uc_rx_fifo: synchronous first-word fall-through FIFO for captured upstream frames
module uc_rx_fifo
    import uc_host_link_pkg::*;
#(
    parameter int WIDTH = UC_ADDR_W + UC_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic             uc_clk,
    input  logic             uc_reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_wr, do_rd;

    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; a write into a full FIFO is legal only alongside a read
    always_ff @(posedge uc_clk or posedge uc_reset) begin
        if (uc_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    // Storage array; contents need no reset because the head is masked while empty
    always_ff @(posedge uc_clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uc_host_link.sv
// uc_host_link: serialises host requests onto uc_in and captures TRANSFER_OUT frames from uc_out
module uc_host_link
    import uc_host_link_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int BUSY_MIN    = 4,
    parameter int RX_DEPTH    = 4
) (
    input  logic                uc_clk,
    input  logic                uc_reset,
    output logic [UC_IN_W-1:0]  uc_in,
    input  logic [UC_OUT_W-1:0] uc_out,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [2:0]          tx_addr,
    input  logic [2:0]          tx_cmd,
    input  logic [7:0]          tx_data,
    output logic                tx_reject,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [2:0]          rx_addr,
    output logic [7:0]          rx_data,
    output logic                rx_overflow
);
    localparam int TW = $clog2(HOLD_CYCLES + GAP_CYCLES + 1);
    localparam int BW = $clog2(BUSY_MIN + 1);

    tx_state_t      state, state_n;
    logic [TW-1:0]  tx_cnt, tx_cnt_n;
    logic           out_of_reset, load, reject_n;
    logic [2:0]     f_addr, f_cmd;
    logic [7:0]     f_data;
    logic           m_q, m_prev;
    logic [2:0]     a_q;
    logic [7:0]     d_q;
    logic [BW-1:0]  busy_cnt;
    logic           push, pop, wr_en, full, empty;
    logic [10:0]    head;
    logic           unused_len;

    // TX state register, latched frame fields and reject pulse
    always_ff @(posedge uc_clk or posedge uc_reset) begin
        if (uc_reset) begin
            state        <= TX_IDLE;
            tx_cnt       <= '0;
            out_of_reset <= 1'b0;
            tx_reject    <= 1'b0;
            f_addr       <= '0;
            f_cmd        <= CMD_NOP;
            f_data       <= '0;
        end else begin
            state        <= state_n;
            tx_cnt       <= tx_cnt_n;
            out_of_reset <= 1'b1;
            tx_reject    <= reject_n;
            if (load) begin
                f_addr <= tx_addr;
                f_cmd  <= tx_cmd;
                f_data <= tx_data;
            end
        end
    end

    // TX next state: accept in idle, then count down the hold and gap phases
    always_comb begin
        state_n  = state;
        tx_cnt_n = tx_cnt;
        load     = 1'b0;
        reject_n = 1'b0;
        tx_ready = out_of_reset && state == TX_IDLE;
        case (state)
            TX_IDLE: if (tx_valid && tx_ready) begin
                if (is_down_cmd(tx_cmd)) begin
                    load     = 1'b1;
                    state_n  = TX_HOLD;
                    tx_cnt_n = TW'(HOLD_CYCLES - 1);
                end else begin
                    reject_n = 1'b1;
                end
            end
            TX_HOLD: begin
                tx_cnt_n = tx_cnt - 1'b1;
                if (tx_cnt == '0) begin
                    state_n  = TX_GAP;
                    tx_cnt_n = TW'(GAP_CYCLES - 1);
                end
            end
            TX_GAP: begin
                tx_cnt_n = tx_cnt - 1'b1;
                if (tx_cnt == '0) state_n = TX_IDLE;
            end
            default: state_n = TX_IDLE;
        endcase
    end

    // uc_in: frame fields only while holding, busy bit independent of TX
    always_comb begin
        uc_in              = UC_IN_IDLE;
        uc_in[UC_BUSY_BIT] = busy_cnt != '0 || full;
        if (state == TX_HOLD) begin
            uc_in[UC_ADDR_LSB +: UC_ADDR_W] = f_addr;
            uc_in[UC_CMD_LSB  +: UC_CMD_W]  = f_cmd;
            uc_in[UC_DATA_LSB +: UC_DATA_W] = f_data;
        end
    end

    assign push       = m_q & ~m_prev;
    assign pop        = rx_valid & rx_ready;
    assign wr_en      = push & (~full | pop);
    assign rx_valid   = ~empty;
    assign {rx_addr, rx_data} = head;
    assign unused_len = ^uc_out[UC_LEN_LSB +: UC_LEN_W];

    // RX capture pipeline, busy hold-off counter and overflow pulse
    always_ff @(posedge uc_clk or posedge uc_reset) begin
        if (uc_reset) begin
            m_q         <= 1'b0;
            m_prev      <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
            busy_cnt    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            m_q         <= uc_out[UC_CMD_LSB +: UC_CMD_W] == CMD_TRANSFER_OUT;
            m_prev      <= m_q;
            a_q         <= uc_out[UC_ADDR_LSB +: UC_ADDR_W];
            d_q         <= uc_out[UC_DATA_LSB +: UC_DATA_W];
            busy_cnt    <= push ? BW'(BUSY_MIN) : busy_cnt != '0 ? busy_cnt - 1'b1 : busy_cnt;
            rx_overflow <= push & full & ~pop;
        end
    end

    uc_rx_fifo #(.WIDTH(UC_ADDR_W + UC_DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .uc_clk   (uc_clk),
        .uc_reset (uc_reset),
        .wr_en    (wr_en),
        .wr_data  ({a_q, d_q}),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty)
    );
endmodule

// File: tb/tb_uc_host_link.sv
// tb_uc_host_link: directed and random stimulus checked every cycle against a timeline model
module tb_uc_host_link;
    localparam int H = 4, G = 2, B = 4, D = 4;

    logic        uc_clk = 0, uc_reset = 1;
    logic [22:0] uc_in;
    logic [21:0] uc_out = '0;
    logic        tx_valid = 0, tx_ready, tx_reject;
    logic [2:0]  tx_addr = '0, tx_cmd = '0;
    logic [7:0]  tx_data = '0;
    logic        rx_valid, rx_ready = 0, rx_overflow;
    logic [2:0]  rx_addr;
    logic [7:0]  rx_data;

    uc_host_link #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BUSY_MIN(B), .RX_DEPTH(D)) dut (
        .uc_clk(uc_clk), .uc_reset(uc_reset), .uc_in(uc_in), .uc_out(uc_out),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_addr(tx_addr), .tx_cmd(tx_cmd),
        .tx_data(tx_data), .tx_reject(tx_reject), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_addr(rx_addr), .rx_data(rx_data), .rx_overflow(rx_overflow)
    );

    always #5 uc_clk = ~uc_clk;

    // Timeline model: edge index k since reset release, event edges recorded as integers
    int          k, idle_from, f_from, f_to, rej_at, ovf_at, last_cap;
    int          n_chk = 0, n_err = 0;
    logic [2:0]  m_addr = '0, m_cmd = '0;
    logic [7:0]  m_data = '0;
    logic        prev_match, pend;
    logic [10:0] pend_val;
    logic [10:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0; idle_from = 1; f_from = 1; f_to = 0; rej_at = -1; ovf_at = -1;
        last_cap = -1000; prev_match = 0; pend = 0; q.delete();
    endtask

    task automatic check_outputs();
        logic        busy, hold;
        logic [22:0] exp_uc;
        busy   = (k - last_cap < B) || q.size() == D;
        hold   = k >= f_from && k <= f_to;
        exp_uc = {busy, 8'h00, hold ? {m_addr, m_cmd, m_data} : 14'h0};
        chk("uc_in", uc_in, exp_uc);
        chk("tx_ready", tx_ready, k >= idle_from);
        chk("tx_reject", tx_reject, rej_at == k);
        chk("rx_valid", rx_valid, q.size() > 0);
        chk("rx_head", {rx_addr, rx_data}, q.size() > 0 ? q[0] : 11'h0);
        chk("rx_overflow", rx_overflow, ovf_at == k);
    endtask

    task automatic step();
        logic full0, pop, match;
        @(posedge uc_clk);
        k++;
        if (tx_valid && k - 1 >= idle_from) begin
            if (tx_cmd inside {3'd1, 3'd2, 3'd3}) begin
                f_from = k; f_to = k + H - 1; idle_from = k + H + G;
                m_addr = tx_addr; m_cmd = tx_cmd; m_data = tx_data;
            end else rej_at = k;
        end
        full0 = q.size() == D;
        pop   = rx_ready && q.size() > 0;
        if (pop) void'(q.pop_front());
        if (pend) begin
            last_cap = k;
            if (!full0 || pop) q.push_back(pend_val);
            else ovf_at = k;
        end
        match      = uc_out[10:8] == 3'd4;
        pend       = match && !prev_match;
        pend_val   = {uc_out[13:11], uc_out[7:0]};
        prev_match = match;
        @(negedge uc_clk);
        check_outputs();
    endtask

    task automatic async_reset();
        uc_reset = 1;
        #1;
        chk("rst_uc_in", uc_in, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_tx_reject", tx_reject, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_head", {rx_addr, rx_data}, 0);
        chk("rst_rx_overflow", rx_overflow, 0);
        repeat (2) @(posedge uc_clk);
        @(negedge uc_clk);
        uc_reset = 0;
        model_reset();
    endtask

    task automatic request(input logic [2:0] a, input logic [2:0] c, input logic [7:0] d);
        tx_valid = 1; tx_addr = a; tx_cmd = c; tx_data = d;
    endtask

    initial begin
        model_reset();
        @(negedge uc_clk);
        async_reset();
        // single request, observed through hold, gap and re-ready
        request(3'd2, 3'd1, 8'hA5);
        repeat (2) step();
        tx_valid = 0;
        repeat (8) step();
        // back-to-back with valid held
        request(3'd6, 3'd3, 8'h11);
        step();
        step();
        tx_data = 8'h22; tx_cmd = 3'd2;
        repeat (14) step();
        tx_valid = 0;
        repeat (2) step();
        // illegal command
        request(3'd1, 3'd4, 8'hFF);
        step();
        tx_valid = 0;
        repeat (3) step();
        // upstream frame held three cycles
        uc_out = {8'h00, 3'd5, 3'd4, 8'h3C};
        repeat (3) step();
        uc_out = '0;
        repeat (6) step();
        rx_ready = 1;
        repeat (2) step();
        rx_ready = 0;
        // five frames into a four-deep FIFO
        for (int i = 0; i < 5; i++) begin
            uc_out = {8'hAA, 3'(i + 1), 3'd4, 8'(8'h40 + i)};
            step();
            uc_out = '0;
            step();
        end
        repeat (6) step();
        rx_ready = 1;
        repeat (6) step();
        rx_ready = 0;
        // reset during hold with FIFO non-empty
        uc_out = {8'h00, 3'd3, 3'd4, 8'h99};
        step();
        uc_out = '0;
        request(3'd7, 3'd1, 8'h5A);
        repeat (3) step();
        tx_valid = 0;
        async_reset();
        request(3'd4, 3'd2, 8'hC3);
        repeat (2) step();
        tx_valid = 0;
        repeat (8) step();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_cmd   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
            tx_addr  = 3'($urandom);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                uc_out = 22'($urandom);
                if ($urandom_range(0, 1) == 1) uc_out[10:8] = 3'd4;
            end
            rx_ready = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 399) == 0) async_reset();
            else step();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
